// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared widths, fetch FSM encoding and buffer entry type
package instr_fetch_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 64'h0;

    // Fetch FSM encoding
    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_DROP  = 2'd2;

    // One instruction buffer entry: 32-bit word plus the address it came from (96 bits)
    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    // Force an address onto a 4-byte boundary
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~(XLEN'(3));
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - instruction memory, decode and redirect signals of the fetch stage
interface instr_fetch_if;
    import instr_fetch_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rvalid;
    logic [ILEN-1:0] imem_rdata;
    logic            if_valid;
    logic [ILEN-1:0] if_instr;
    logic [6:0]      if_opcode;
    logic [XLEN-1:0] if_pc;
    logic            id_ready;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;

    // Fetch stage side
    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_opcode, if_pc,
        input  imem_rvalid, imem_rdata, id_ready, redirect, redirect_pc
    );

    // Memory / decode / branch-unit side
    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_opcode, if_pc,
        output imem_rvalid, imem_rdata, id_ready, redirect, redirect_pc
    );

endinterface

// File: rtl/instr_fetch_fifo.sv
// rtl/instr_fetch_fifo.sv - two-entry instruction buffer with push, pop, flush and count
module fetch_fifo
    import instr_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic         head_valid,
    output fetch_entry_t head_data,
    output logic [1:0]   count
);

    fetch_entry_t mem_q [2];
    fetch_entry_t mem_d [2];
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    // Next-state of storage and pointers; flush wins over push/pop, pop on empty is dropped
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != 2'd0);
        do_push  = push && ((count_q != 2'd2) || do_pop);
        if (flush) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // Buffer state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // An empty buffer presents zeros rather than stale contents
    assign head_valid = (count_q != 2'd0);
    assign head_data  = head_valid ? mem_q[rd_ptr_q] : '0;
    assign count      = count_q;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - single-outstanding-request instruction fetch stage with redirect flush
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int              FIFO_DEPTH = 2
) (
    input logic         clk,
    input logic         reset,
    instr_fetch_if.master bus
);

    localparam logic [1:0] DEPTH_C = 2'(FIFO_DEPTH);

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;

    logic            req;
    logic            push;
    logic            pop;
    logic            flush;
    logic            head_valid;
    logic [1:0]      count;
    fetch_entry_t    push_data;
    fetch_entry_t    head;

    // Fetch FSM: redirect overrides everything; a response seen while redirecting or in DROP is discarded
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        req        = 1'b0;
        push       = 1'b0;
        flush      = 1'b0;
        if (bus.redirect) begin
            flush = 1'b1;
            pc_d  = align_word(bus.redirect_pc);
            case (state_q)
                ST_WAIT:  state_d = bus.imem_rvalid ? ST_FETCH : ST_DROP;
                ST_DROP:  state_d = bus.imem_rvalid ? ST_FETCH : ST_DROP;
                default:  state_d = ST_FETCH;
            endcase
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (count < DEPTH_C) begin
                        req        = 1'b1;
                        req_addr_d = pc_q;
                        pc_d       = pc_q + 64'd4;
                        state_d    = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.imem_rvalid) begin
                        push    = 1'b1;
                        state_d = ST_FETCH;
                    end
                end
                ST_DROP: begin
                    if (bus.imem_rvalid) begin
                        state_d = ST_FETCH;
                    end
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

    // FSM, pc and outstanding-request address registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            req_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    assign push_data.instr = bus.imem_rdata;
    assign push_data.pc    = req_addr_q;
    assign pop             = head_valid && bus.id_ready && !bus.redirect;

    fetch_fifo u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_data  (push_data),
        .pop        (pop),
        .flush      (flush),
        .head_valid (head_valid),
        .head_data  (head),
        .count      (count)
    );

    // Request is held low while reset is asserted even though the FSM already sits in FETCH
    assign bus.imem_req  = req && !reset;
    assign bus.imem_addr = pc_q;
    assign bus.if_valid  = head_valid;
    assign bus.if_instr  = head.instr;
    assign bus.if_pc     = head.pc;
    assign bus.if_opcode = head.instr[6:0];

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard testbench for instr_fetch
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    instr_fetch_if bus ();
    instr_fetch_if bus1 ();

    instr_fetch #(.RESET_PC(64'h0), .FIFO_DEPTH(2)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    instr_fetch #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .FIFO_DEPTH(2)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    typedef struct {
        logic [63:0] addr;
        int          cyc;
    } req_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        int          cyc;
    } del_t;

    req_t req_q [$];
    del_t del_q [$];
    req_t mon_r;
    del_t mon_d;

    int n_checks = 0;
    int n_errors = 0;
    int cyc;

    bit          mon_en    = 1'b1;
    bit          auto_resp = 1'b0;
    logic        auto_v    = 1'b0;
    logic [31:0] auto_d    = '0;
    logic        man_v     = 1'b0;
    logic [31:0] man_d     = '0;
    logic        man1_v    = 1'b0;
    logic [31:0] man1_d    = '0;
    logic [63:0] resp_addr;

    assign bus.imem_rvalid  = auto_v | man_v;
    assign bus.imem_rdata   = auto_v ? auto_d : man_d;
    assign bus1.imem_rvalid = man1_v;
    assign bus1.imem_rdata  = man1_d;

    // cycle 1 is the first clock period after reset release
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return {a[23:0], 8'h13};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_req(input logic [63:0] a, input int c);
        req_t r;
        r.addr = a;
        r.cyc  = c;
        req_q.push_back(r);
    endtask

    task automatic exp_del(input logic [63:0] pc, input logic [31:0] ins, input int c);
        del_t d;
        d.pc    = pc;
        d.instr = ins;
        d.cyc   = c;
        del_q.push_back(d);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_req"},   64'(bus.imem_req),  64'h0);
        chk({tag, "_valid"}, 64'(bus.if_valid),  64'h0);
        chk({tag, "_instr"}, 64'(bus.if_instr),  64'h0);
        chk({tag, "_pc"},    bus.if_pc,          64'h0);
        chk({tag, "_req1"},  64'(bus1.imem_req), 64'h0);
    endtask

    task automatic apply_reset(input bit auto_mode, input logic rdy);
        chk("req_queue_drained", 64'(req_q.size()), 64'h0);
        chk("del_queue_drained", 64'(del_q.size()), 64'h0);
        req_q.delete();
        del_q.delete();
        reset           = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.id_ready    = rdy;
        man_v           = 1'b0;
        auto_resp       = auto_mode;
        step(1);
        chk_zero_outputs("reset");
        step(2);
        reset = 1'b0;
    endtask

    // Memory responder: answers each request one cycle later with mem_word(addr)
    always begin
        @(negedge clk);
        if (auto_resp && !reset && bus.imem_req) begin
            resp_addr = bus.imem_addr;
            @(posedge clk);
            #1;
            auto_v = 1'b1;
            auto_d = mem_word(resp_addr);
            @(posedge clk);
            #1;
            auto_v = 1'b0;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT issues a request or hands over an instruction
    always @(negedge clk) begin
        if (!reset && mon_en) begin
            if (bus.imem_req) begin
                if (req_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_req: got addr %h at cycle %0d, expected no request", bus.imem_addr, cyc + 1);
                end else begin
                    mon_r = req_q.pop_front();
                    chk("req_addr",  bus.imem_addr, mon_r.addr);
                    chk("req_cycle", 64'(cyc + 1),  64'(mon_r.cyc));
                end
            end
            if (bus.if_valid && bus.id_ready && !bus.redirect) begin
                if (del_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_instr: got pc %h instr %h at cycle %0d, expected nothing", bus.if_pc, bus.if_instr, cyc + 1);
                end else begin
                    mon_d = del_q.pop_front();
                    chk("if_pc",     bus.if_pc,             mon_d.pc);
                    chk("if_instr",  64'(bus.if_instr),     64'(mon_d.instr));
                    chk("if_opcode", 64'(bus.if_opcode),    64'(mon_d.instr[6:0]));
                    chk("del_cycle", 64'(cyc + 1),          64'(mon_d.cyc));
                end
            end else if (!bus.if_valid) begin
                chk("empty_instr", 64'(bus.if_instr), 64'h0);
                chk("empty_pc",    bus.if_pc,         64'h0);
            end
        end
    end

    initial begin
        bus.id_ready     = 1'b1;
        bus.redirect     = 1'b0;
        bus.redirect_pc  = '0;
        bus1.id_ready    = 1'b1;
        bus1.redirect    = 1'b0;
        bus1.redirect_pc = '0;

        // Streaming fetch, decode always ready
        apply_reset(1'b1, 1'b1);
        exp_req(64'h0, 1);
        exp_req(64'h4, 3);
        exp_req(64'h8, 5);
        exp_req(64'hC, 7);
        exp_del(64'h0, 32'h0000_0013, 3);
        exp_del(64'h4, 32'h0000_0413, 5);
        exp_del(64'h8, 32'h0000_0813, 7);
        step(7);

        // Backpressure: buffer fills at two entries, one pop frees a slot
        apply_reset(1'b1, 1'b0);
        exp_req(64'h0, 1);
        exp_req(64'h4, 3);
        exp_req(64'h8, 8);
        exp_del(64'h0, 32'h0000_0013, 7);
        exp_del(64'h4, 32'h0000_0413, 10);
        step(6);
        chk("full_head_pc",     bus.if_pc,             64'h0);
        chk("full_head_opcode", 64'(bus.if_opcode),    64'h13);
        bus.id_ready = 1'b1;
        step(1);
        bus.id_ready = 1'b0;
        step(2);
        bus.id_ready = 1'b1;
        step(1);

        // Redirect in FETCH with a full buffer flushes it; redirect_pc[1:0] ignored
        apply_reset(1'b1, 1'b0);
        exp_req(64'h0, 1);
        exp_req(64'h4, 3);
        exp_req(64'h40, 6);
        exp_req(64'h44, 8);
        exp_del(64'h40, 32'h0000_4013, 8);
        step(4);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 64'h43;
        step(1);
        bus.redirect = 1'b0;
        chk("flush_valid", 64'(bus.if_valid), 64'h0);
        bus.id_ready = 1'b1;
        step(3);

        // Redirect while waiting: late response dropped, refetch from 0x100
        apply_reset(1'b0, 1'b1);
        exp_req(64'h0, 1);
        exp_req(64'h100, 5);
        exp_req(64'h104, 7);
        exp_del(64'h100, 32'h0640_0093, 7);
        step(1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 64'h103;
        step(1);
        bus.redirect = 1'b0;
        step(1);
        man_v = 1'b1;
        man_d = 32'hDEAD_BEEF;
        step(1);
        man_v = 1'b0;
        chk("drop_valid", 64'(bus.if_valid), 64'h0);
        step(1);
        man_v = 1'b1;
        man_d = 32'h0640_0093;
        step(1);
        man_v = 1'b0;
        step(1);

        // Redirect coinciding with the response: response discarded
        apply_reset(1'b0, 1'b1);
        exp_req(64'h0, 1);
        exp_req(64'h200, 3);
        exp_req(64'h204, 5);
        exp_del(64'h200, 32'h00A0_0513, 5);
        step(1);
        man_v           = 1'b1;
        man_d           = 32'h0000_0013;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 64'h200;
        step(1);
        man_v        = 1'b0;
        bus.redirect = 1'b0;
        chk("coincide_valid", 64'(bus.if_valid), 64'h0);
        step(1);
        man_v = 1'b1;
        man_d = 32'h00A0_0513;
        step(1);
        man_v = 1'b0;
        step(1);

        // Reset mid-WAIT with stale responses during and after reset
        apply_reset(1'b0, 1'b1);
        exp_req(64'h0, 1);
        step(1);
        reset = 1'b1;
        man_v = 1'b1;
        man_d = 32'hBADB_AD13;
        #1;
        chk_zero_outputs("midwait_reset");
        step(1);
        man_v = 1'b0;
        step(1);
        exp_req(64'h0, 1);
        exp_req(64'h4, 4);
        exp_del(64'h0, 32'h1111_1113, 4);
        reset = 1'b0;
        man_v = 1'b1;
        man_d = 32'hBADB_AD13;
        step(1);
        man_v = 1'b0;
        chk("stale_valid_c2", 64'(bus.if_valid), 64'h0);
        step(1);
        chk("stale_valid_c3", 64'(bus.if_valid), 64'h0);
        man_v = 1'b1;
        man_d = 32'h1111_1113;
        step(1);
        man_v = 1'b0;
        step(1);

        // Non-zero RESET_PC wraps to address 0
        mon_en = 1'b0;
        apply_reset(1'b0, 1'b1);
        #2;
        chk("wrap_req0",  64'(bus1.imem_req), 64'h1);
        chk("wrap_addr0", bus1.imem_addr,     64'hFFFF_FFFF_FFFF_FFFC);
        step(1);
        man1_v = 1'b1;
        man1_d = 32'h0000_0013;
        step(1);
        man1_v = 1'b0;
        #1;
        chk("wrap_req1",   64'(bus1.imem_req), 64'h1);
        chk("wrap_addr1",  bus1.imem_addr,     64'h0);
        chk("wrap_valid",  64'(bus1.if_valid), 64'h1);
        chk("wrap_pc",     bus1.if_pc,         64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_instr",  64'(bus1.if_instr), 64'h13);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
